cim_access_ctrl: RTL and testbench

Access sequencer that drives the row_decoder control interface (CS, MAC_en, read_bar, w_en, addr, data) of the CIM SRAM macro. It accepts one read, write or MAC request at a time over a valid/ready handshake. Each request is expanded into timed phases: precharge, wordline activation and sense. For read and MAC it returns the sensed column result to the requester.

---
 rtl/cim_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cim_access_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cim_access_ctrl.sv
// Access sequencer for the CIM SRAM row_decoder: expands one read/write/MAC request
// into precharge, wordline and sense phases and returns the sensed column result.
module cim_access_ctrl #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 4,
  parameter int PRE_CYCLES   = 1,
  parameter int WL_CYCLES    = 2,
  parameter int SENSE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [DATA_W-1:0] rd_in,
  output logic              CS,
  output logic              MAC_en,
  output logic              read_bar,
  output logic              w_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              precharge_en,
  output logic              sense_en,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int MAX_A  = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int MAX_PH = (MAX_A > SENSE_CYCLES) ? MAX_A : SENSE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_PH) + 1;

  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LOAD    = CNT_W'(WL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_CYCLES - 1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_SENSE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_op;
  logic [1:0]       w_op_nxt;
  logic             w_accept;
  logic             w_capture;
  logic             w_act_nxt;

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_op_nxt  = w_accept ? req_op : r_op;
  assign w_capture = (r_state == S_SENSE) && (r_cnt == '0);
  assign w_act_nxt = (w_state_nxt == S_ACT);

  // The phase counter counts down to zero and is reloaded on every phase entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (req_op == OP_RSV) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_PRE;
            w_cnt_nxt   = PRE_LOAD;
          end
        end
      end
      S_PRE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ACT;
          w_cnt_nxt   = WL_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ACT: begin
        if (r_cnt == '0) begin
          if (r_op == OP_WR) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SENSE;
            w_cnt_nxt   = SENSE_LOAD;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_SENSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Array strobes are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_op         <= OP_RD;
      addr         <= '0;
      data         <= '0;
      CS           <= 1'b0;
      MAC_en       <= 1'b0;
      read_bar     <= 1'b1;
      w_en         <= 1'b0;
      precharge_en <= 1'b0;
      sense_en     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      if (w_accept) begin
        r_op <= req_op;
        addr <= req_addr;
        data <= req_data;
      end
      CS           <= w_act_nxt;
      MAC_en       <= w_act_nxt && (w_op_nxt == OP_MAC);
      read_bar     <= !(w_act_nxt && (w_op_nxt == OP_RD));
      w_en         <= w_act_nxt && (w_op_nxt == OP_WR);
      precharge_en <= (w_state_nxt == S_PRE);
      sense_en     <= (w_state_nxt == S_SENSE);
      done         <= (w_state_nxt == S_DONE);
      err          <= (w_state_nxt == S_DONE) && (w_op_nxt == OP_RSV);
      rsp_valid    <= (w_state_nxt == S_DONE) &&
                      ((w_op_nxt == OP_RD) || (w_op_nxt == OP_MAC));
      if (w_capture) begin
        rsp_data <= rd_in;
      end
    end
  end

endmodule

// File: tb/tb_cim_access_ctrl.sv
// Self-checking bench for cim_access_ctrl: directed and random requests, a per-cycle
// phase model derived from accept time, and a response scoreboard popped on done.
module tb_cim_access_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int P = 1;
  localparam int W = 2;
  localparam int S = 1;
  localparam int HIST = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] rd_in;
  logic              CS, MAC_en, read_bar, w_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              precharge_en, sense_en, rsp_valid, done, err, busy;
  logic [DATA_W-1:0] rsp_data;

  cim_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .PRE_CYCLES(P), .WL_CYCLES(W), .SENSE_CYCLES(S)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data), .rd_in(rd_in),
    .CS(CS), .MAC_en(MAC_en), .read_bar(read_bar), .w_en(w_en),
    .addr(addr), .data(data), .precharge_en(precharge_en), .sense_en(sense_en),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] op;
    int         acc;
  } txn_t;

  txn_t              q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [DATA_W-1:0] exp_rsp  = '0;
  logic [DATA_W-1:0] rd_hist[HIST];
  int                errors = 0;
  int                nchk   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Phase of a request 'o' cycles after its accept edge: 0 idle,1 pre,2 act,3 sense,4 done.
  function automatic int phase_of(input logic [1:0] op, input int o);
    if (o < 1) return 0;
    if (op == 2'b11) return (o == 1) ? 4 : 0;
    if (o <= P) return 1;
    if (o <= P + W) return 2;
    if (op == 2'b01) return (o == P + W + 1) ? 4 : 0;
    if (o <= P + W + S) return 3;
    if (o == P + W + S + 1) return 4;
    return 0;
  endfunction

  // Random sense-amp data, changed just after each rising edge.
  initial begin
    rd_in = '0;
    forever begin
      @(posedge clk);
      #1 rd_in = DATA_W'($urandom);
    end
  end

  // Monitor: one expected-output vector per cycle, response compared on done.
  initial begin
    int         c, o, ph;
    logic [1:0] op;
    logic [10:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      c = cyc;
      rd_hist[c % HIST] = rd_in;
      ph = 0;
      op = 2'b00;
      if (!rst && q.size() > 0) begin
        op = q[0].op;
        o  = c - q[0].acc;
        ph = phase_of(op, o);
      end
      if (ph == 4 && (op == 2'b00 || op == 2'b10))
        exp_rsp = rd_hist[(c - 1) % HIST];
      exp_v = {ph == 0, ph != 0, ph == 2, ph == 2 && op == 2'b10,
               !(ph == 2 && op == 2'b00), ph == 2 && op == 2'b01,
               ph == 1, ph == 3, ph == 4 && (op == 2'b00 || op == 2'b10),
               ph == 4, ph == 4 && op == 2'b11};
      act_v = {req_ready, busy, CS, MAC_en, read_bar, w_en,
               precharge_en, sense_en, rsp_valid, done, err};
      check("ctrl_vec{rdy,busy,cs,mac,rdb,wen,pre,sen,rv,done,err}", 32'(act_v), 32'(exp_v));
      check("addr", 32'(addr), 32'(exp_addr));
      check("data", 32'(data), 32'(exp_data));
      check("rsp_data", 32'(rsp_data), 32'(exp_rsp));
      if (ph == 4) void'(q.pop_front());
    end
  end

  task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input int gap);
    int   n;
    txn_t t;
    if (gap > 0) begin
      @(negedge clk);
      req_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
    @(negedge clk);
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    if (!req_ready) return;
    @(posedge clk);
    #1;
    t.op  = op;
    t.acc = cyc - 1;
    q.push_back(t);
    exp_addr = a;
    exp_data = d;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_data  = '0;
    #1;
    check("reset_cs", 32'(CS), 32'd0);
    check("reset_read_bar", 32'(read_bar), 32'd1);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    send(2'b01, 2'b01, 4'b1010, 1);
    send(2'b00, 2'b10, 4'b0000, 0);
    send(2'b10, 2'b00, 4'b0110, 0);
    send(2'b11, 2'b11, 4'b1111, 2);
    send(2'b01, 2'b10, 4'b0101, 0);
    send(2'b00, 2'b01, 4'b0011, 0);

    // Abort a read during its wordline phase.
    send(2'b00, 2'b10, 4'b0000, 2);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("abort_cs_before", 32'(CS), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_cs", 32'(CS), 32'd0);
    check("abort_read_bar", 32'(read_bar), 32'd1);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    q.delete();
    exp_addr = '0;
    exp_data = '0;
    exp_rsp  = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) @(posedge clk);

    for (int i = 0; i < 60; i++)
      send(2'($urandom_range(0, 3)), ADDR_W'($urandom), DATA_W'($urandom),
           int'($urandom_range(0, 2)));

    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
